// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter and sequencer for the shared 64-bit memory port.
// Optional macro ARB_RR_EN selects round-robin collision handling (default: data always wins).
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [63:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [63:0]       mem_wdata,
  input  logic [63:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

  state_t              state, state_next;
  logic                owner;      // 1 = data port, 0 = fetch port
  logic [ADDR_W-1:2]   addr;
  logic                we;
  logic                misal;
  logic [63:0]         wdata;
  logic [3:0]          cnt;
  logic                arb, take, pick_data;

  // Fetch addresses are word-granular; their low two bits carry no information.
  logic unused_if_addr;
  assign unused_if_addr = ^if_addr[1:0];

`ifdef ARB_RR_EN
  logic last_data;
  assign pick_data = d_req && (!if_req || !last_data);
`else
  assign pick_data = d_req;
`endif

  assign arb  = (state == IDLE) || (state == DONE);
  assign take = arb && (if_req || d_req);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state    <= IDLE;
      owner    <= 1'b0;
      addr     <= '0;
      we       <= 1'b0;
      misal    <= 1'b0;
      wdata    <= '0;
      cnt      <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
`ifdef ARB_RR_EN
      last_data <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (take) begin
        owner <= pick_data;
        addr  <= pick_data ? d_addr[ADDR_W-1:2] : if_addr[ADDR_W-1:2];
        we    <= pick_data && d_we;
        misal <= pick_data && (d_addr[2:0] != 3'b000);
        wdata <= d_wdata;
`ifdef ARB_RR_EN
        last_data <= pick_data;
`endif
      end
      if (state == ISSUE) begin
        cnt <= misal ? 4'd0 : CNT_LOAD;
      end else if (state == WAIT) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else if (!misal) begin
          // Last wait cycle: memory data is valid now.
          if (!owner)
            if_rdata <= addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
          else if (!we)
            d_rdata <= mem_rdata;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    if_rvalid  = 1'b0;
    d_rvalid   = 1'b0;
    d_err      = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: state_next = take ? ISSUE : IDLE;
      ISSUE: begin
        if_gnt     = !owner;
        d_gnt      = owner;
        mem_en     = !misal;
        mem_we     = !misal && we;
        state_next = WAIT;
      end
      WAIT: state_next = (cnt == 4'd0) ? DONE : WAIT;
      DONE: begin
        if_rvalid  = !owner;
        d_rvalid   = owner;
        d_err      = owner && misal;
        state_next = take ? ISSUE : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_addr  = {addr[ADDR_W-1:3], 3'b000};
  assign mem_wdata = wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 main instance plus a MEM_LAT=1 instance for rate checks.
module tb_mem_port_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr;
  logic [63:0] d_wdata;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, d_err;
  logic [31:0] if_rdata;
  logic [63:0] d_rdata;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;

  logic        if_req1;
  logic        if_gnt1, if_rvalid1, d_gnt1, d_rvalid1, d_err1, mem_en1, mem_we1, busy1;
  logic [31:0] if_rdata1, mem_addr1;
  logic [63:0] d_rdata1, mem_wdata1;
  logic [63:0] mem_rdata1 = 64'h0123_4567_89AB_CDEF;

  int checks = 0;
  int errors = 0;
  int rv_count = 0;
  int rv_before;
  int d_cnt, i_cnt;
  logic [3:0] exp_own;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .MEM_LAT(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(32), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req1), .if_addr(32'h0000_0040), .if_gnt(if_gnt1), .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'h0), .d_wdata(64'h0), .d_gnt(d_gnt1),
    .d_rvalid(d_rvalid1), .d_rdata(d_rdata1), .d_err(d_err1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata1), .busy(busy1)
  );

  // Memory model: data is valid only in the cycle exactly LAT cycles after mem_en.
  logic [63:0] mem [0:255];
  logic [63:0] pd [1:LAT];
  logic        pv [1:LAT];
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr[10:3]] <= mem_wdata;
    pd[1] <= mem[mem_addr[10:3]];
    pv[1] <= mem_en;
    for (int i = 2; i <= LAT; i++) begin
      pd[i] <= pd[i-1];
      pv[i] <= pv[i-1];
    end
  end
  assign mem_rdata = pv[LAT] ? pd[LAT] : 64'hDEAD_BEEF_DEAD_BEEF;

  always @(posedge clk) if (if_rvalid || d_rvalid) rv_count <= rv_count + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef ARB_RR_EN
    exp_own = 4'b0101;
`else
    exp_own = 4'b0011;
`endif
    for (int i = 0; i < 256; i++) mem[i] = 64'h0;
    mem[8'h20] = 64'hAAAA_BBBB_CCCC_DDDD;  // byte address 0x100
    rst_n = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0; if_req1 = 0;
    tick(); tick();
    chk("rst_busy", 64'(busy), 0);
    chk("rst_mem_en", 64'(mem_en), 0);
    chk("rst_strobes", 64'({if_gnt, d_gnt, if_rvalid, d_rvalid, d_err, mem_we}), 0);
    chk("rst_rdata", {if_rdata, 32'h0} | d_rdata, 0);
    chk("rst_mem_bus", 64'(mem_addr) | mem_wdata, 0);
    rst_n = 1'b0;
    tick();

    // Fetch 0x104: grant cycle 1, rvalid cycle 4, upper word.
    if_req = 1; if_addr = 32'h104;
    chk("f_idle_busy", 64'(busy), 0);
    tick();
    chk("f_if_gnt", 64'(if_gnt), 1);
    chk("f_mem_en", 64'(mem_en), 1);
    chk("f_mem_addr", 64'(mem_addr), 64'h100);
    chk("f_mem_we", 64'(mem_we), 0);
    if_req = 0;
    tick();
    chk("f_wait_busy", 64'(busy), 1);
    chk("f_wait_rvalid", 64'(if_rvalid), 0);
    tick(); tick();
    chk("f_if_rvalid", 64'(if_rvalid), 1);
    chk("f_if_rdata", 64'(if_rdata), 64'hAAAA_BBBB);
    chk("f_d_rvalid", 64'(d_rvalid), 0);
    tick();
    chk("f_back_idle", 64'(busy), 0);

    // Store to 0x200 then load it back.
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 64'h1122_3344_5566_7788;
    tick();
    chk("st_d_gnt", 64'(d_gnt), 1);
    chk("st_mem_en_we", 64'({mem_en, mem_we}), 64'b11);
    chk("st_mem_addr", 64'(mem_addr), 64'h200);
    chk("st_mem_wdata", mem_wdata, 64'h1122_3344_5566_7788);
    d_req = 0; d_wdata = 64'h0;
    tick(); tick(); tick();
    chk("st_d_rvalid", 64'(d_rvalid), 1);
    chk("st_d_err", 64'(d_err), 0);
    chk("st_d_rdata_kept", d_rdata, 0);
    tick();
    d_req = 1; d_we = 0; d_addr = 32'h200;
    tick();
    chk("ld_gnt_en_we", 64'({d_gnt, mem_en, mem_we}), 64'b110);
    d_req = 0;
    tick(); tick(); tick();
    chk("ld_d_rvalid", 64'(d_rvalid), 1);
    chk("ld_d_rdata", d_rdata, 64'h1122_3344_5566_7788);
    chk("ld_d_err", 64'(d_err), 0);
    tick();

    // Collisions: two data and two fetch requests pending from the same IDLE cycle.
    d_cnt = 2; i_cnt = 2;
    if_addr = 32'h100; d_addr = 32'h200; d_we = 0;
    d_req = 1; if_req = 1;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk($sformatf("coll%0d_d_gnt", t), 64'(d_gnt), 64'(exp_own[t]));
      chk($sformatf("coll%0d_if_gnt", t), 64'(if_gnt), 64'(!exp_own[t]));
      if (d_gnt) d_cnt--;
      if (if_gnt) i_cnt--;
      d_req = (d_cnt > 0);
      if_req = (i_cnt > 0);
      tick(); tick(); tick();
      chk($sformatf("coll%0d_rvalid", t), 64'({d_rvalid, if_rvalid}), exp_own[t] ? 64'b10 : 64'b01);
      chk($sformatf("coll%0d_done_gnt", t), 64'({d_gnt, if_gnt}), 0);
      if (exp_own[t]) chk($sformatf("coll%0d_d_rdata", t), d_rdata, 64'h1122_3344_5566_7788);
      else chk($sformatf("coll%0d_if_rdata", t), 64'(if_rdata), 64'hCCCC_DDDD);
    end
    tick();
    chk("coll_idle", 64'(busy), 0);

    // Misaligned load 0x203: no memory access, d_err with d_rvalid in cycle 3.
    d_req = 1; d_we = 0; d_addr = 32'h203;
    tick();
    chk("mis_d_gnt", 64'(d_gnt), 1);
    chk("mis_mem_en1", 64'(mem_en), 0);
    d_req = 0;
    tick();
    chk("mis_mem_en2", 64'(mem_en), 0);
    chk("mis_early_rvalid", 64'(d_rvalid), 0);
    tick();
    chk("mis_rvalid_err", 64'({d_rvalid, d_err, mem_en}), 64'b110);
    chk("mis_d_rdata_kept", d_rdata, 64'h1122_3344_5566_7788);
    tick();
    chk("mis_idle", 64'(busy), 0);

    // Reset during WAIT abandons the access.
    if_req = 1; if_addr = 32'h104;
    tick();
    if_req = 0;
    tick();
    chk("rw_in_wait", 64'(busy), 1);
    rv_before = rv_count;
    rst_n = 1'b1;
    #1;
    chk("rw_async_busy_en", 64'({busy, mem_en}), 0);
    tick();
    rst_n = 1'b0;
    tick(); tick(); tick();
    chk("rw_no_rvalid", 64'(rv_count - rv_before), 0);
    chk("rw_if_rdata_cleared", 64'(if_rdata), 0);
    if_req = 1; if_addr = 32'h104;
    tick();
    chk("rw_new_gnt", 64'({if_gnt, mem_en}), 64'b11);
    if_req = 0;
    tick(); tick(); tick();
    chk("rw_new_rvalid", 64'(if_rvalid), 1);
    chk("rw_new_rdata", 64'(if_rdata), 64'hAAAA_BBBB);
    tick();

    // MEM_LAT=1, continuous fetch: grant every third cycle, rvalid just before the next grant.
    if_req1 = 1;
    for (int r = 0; r < 3; r++) begin
      tick();
      chk($sformatf("lat1_r%0d_gnt", r), 64'({if_gnt1, if_rvalid1}), 64'b10);
      tick();
      chk($sformatf("lat1_r%0d_wait", r), 64'({if_gnt1, if_rvalid1}), 64'b00);
      tick();
      chk($sformatf("lat1_r%0d_rvalid", r), 64'({if_gnt1, if_rvalid1}), 64'b01);
    end
    chk("lat1_if_rdata", 64'(if_rdata1), 64'h89AB_CDEF);
    if_req1 = 0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter for the single 64-bit memory port shared by instruction fetch and load/store. Sits between the control unit's fetch/data request strobes and the memory macro. It serialises accesses, waits out the fixed memory latency and returns read data with a one-cycle valid pulse. Misaligned doubleword accesses are rejected without touching memory.

## Interface
- ADDR_W, 32, byte-address width
- MEM_LAT, 2, cycles from the mem_en cycle to valid mem_rdata (legal range 1–15)

- clk  in  1  clock
- rst_n  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDR_W  fetch byte address
- if_gnt  out  1  one-cycle grant pulse to fetch
- if_rvalid  out  1  one-cycle fetch data valid
- if_rdata  out  32  fetched instruction word
- d_req  in  1  data request, held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  64  store data
- d_gnt  out  1  one-cycle grant pulse to data
- d_rvalid  out  1  one-cycle completion pulse (loads and stores)
- d_rdata  out  64  load data
- d_err  out  1  misalignment flag, valid with d_rvalid
- mem_en  out  1  memory access strobe, one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  doubleword address, bits [2:0] forced to 0
- mem_wdata  out  64  memory write data
- mem_rdata  in  64  memory read data
- busy  out  1  high in any state other than IDLE

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT and DONE.
- **Arbitration** happens in IDLE and in DONE.
  - If any request is high, the FSM latches owner, addr, we and wdata, then goes to ISSUE.
  - With no request it goes to (or stays in) IDLE.
  - On collision, data wins (see Configuration).
- **ISSUE** (one cycle):
  - Pulses the owner's gnt.
  - Drives mem_en=1, mem_we = latched we (fetch: 0), mem_addr = {addr[ADDR_W-1:3],3'b000}, mem_wdata = latched wdata.
  - Loads the counter with MEM_LAT-1, then goes to WAIT.
- **Misaligned data access** (d_addr[2:0] != 0):
  - The FSM still enters ISSUE and pulses d_gnt.
  - mem_en stays 0 and the WAIT counter is loaded with 0.
  - d_err=1 is pulsed with d_rvalid in DONE.
  - d_rdata is not updated.
- **WAIT**: the counter decrements each cycle. When the counter is 0, mem_rdata is sampled at the end of that cycle and the FSM goes to DONE.
  - Fetch: if_rdata <= addr[2] ? mem_rdata[63:32] : mem_rdata[31:0].
  - Load: d_rdata <= mem_rdata.
  - Store: no data register is updated.
- **DONE** (one cycle): pulses the owner's rvalid, then arbitrates as in IDLE.
- if_rdata and d_rdata hold their values until the next completed read to that port.
- Fetch addresses ignore bits [1:0].
- A request is taken only when its req is high in an arbitration cycle. req dropped before gnt means no access.

## Timing
- Reset values:
  - state IDLE.
  - All gnt, rvalid, err, mem_en, mem_we and busy outputs are 0.
  - if_rdata, d_rdata, mem_addr and mem_wdata are 0.
  - Latched owner is fetch.
  - Counter is 0.
- Reset asserted mid-transaction abandons the access immediately: mem_en falls asynchronously and no rvalid is produced.
- Latency, for a request first high in IDLE cycle 0:
  - gnt and mem_en in cycle 1.
  - WAIT in cycles 2..1+MEM_LAT.
  - rvalid in cycle 2+MEM_LAT.
- Back-to-back: a request pending in DONE is issued in the next cycle. Peak rate is one access per MEM_LAT+2 cycles.
- gnt and rvalid for the same transaction are never in the same cycle. At most one rvalid is high per cycle.
- Latched fields are immune to requester input changes after the arbitration cycle.

## Configuration
- ARB_RR_EN defined:
  - On collision, the port not served by the most recent grant wins.
  - The last-grant register resets to fetch, so the first collision goes to data.
- ARB_RR_EN undefined: data always wins on collision, and fetch waits.
- Non-collision behaviour is identical in both builds.

## Test plan
- MEM_LAT=2, fetch if_addr=0x104, memory word at 0x100 = 0xAAAA_BBBB_CCCC_DDDD:
  - if_gnt in cycle 1, mem_addr=0x100, mem_en=1.
  - if_rvalid in cycle 4 with if_rdata=0xAAAA_BBBB.
- Store d_addr=0x200, d_wdata=0x1122_3344_5566_7788, then load 0x200:
  - First access: mem_we=1 in its ISSUE cycle and d_rvalid with d_err=0.
  - Second access: d_rdata=0x1122_3344_5566_7788.
- if_req and d_req high together in IDLE, repeated twice:
  - Default build: data, data, then fetch.
  - ARB_RR_EN build: data, fetch, data, fetch.
- Load d_addr=0x203:
  - d_gnt pulses and mem_en is never 1.
  - d_rvalid and d_err are 1 in cycle 3.
  - d_rdata is unchanged.
- Reset pulsed while in WAIT:
  - busy and mem_en drop to 0 immediately.
  - No rvalid is produced.
  - A new fetch after reset completes with nominal latency.
- MEM_LAT=1 with continuous if_req: if_gnt is pulsed every 3 cycles, and each if_rvalid precedes the next if_gnt.
